// File: rtl/gtf_qpll_supervisor.sv
// gtf_qpll_supervisor: power-up, reset and lock supervisor for GTF QPLLs.
// One shared clock, one independent sequencer per PLL.
module gtf_qpll_supervisor #(
  parameter int NUM_PLL      = 2,
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_FILTER  = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic                   gtf_cm_drpclk,
  input  logic                   gtf_cm_reset,
  input  logic [NUM_PLL-1:0]     pll_enable,
  input  logic [NUM_PLL-1:0]     qpll_lock,
  input  logic [NUM_PLL-1:0]     qpll_refclklost,
  output logic [NUM_PLL-1:0]     qpll_pd,
  output logic [NUM_PLL-1:0]     qpll_reset,
  output logic [NUM_PLL-1:0]     qpll_locken,
  output logic [NUM_PLL-1:0]     pll_ready,
  output logic [NUM_PLL-1:0]     pll_fail,
  output logic [3*NUM_PLL-1:0]   pll_state,
  output logic [8*NUM_PLL-1:0]   lock_loss_cnt
);

  localparam int TMAX = (RST_CYCLES > LOCK_TIMEOUT) ?
                        RST_CYCLES : LOCK_TIMEOUT;
  localparam int TW = $clog2(TMAX) + 1;
  localparam int FW = $clog2(LOCK_FILTER) + 1;
  localparam int RW = $clog2(MAX_RETRY) + 1;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_PDREL = 3'd1,
    ST_LWAIT = 3'd2,
    ST_READY = 3'd3,
    ST_HOLD  = 3'd4,
    ST_FAIL  = 3'd5
  } st_e;

  logic [NUM_PLL-1:0] lock_s1_q, lock_s2_q;
  logic [NUM_PLL-1:0] rcl_s1_q, rcl_s2_q;

  // Two-flop synchronisers for the asynchronous PLL status inputs
  always_ff @(posedge gtf_cm_drpclk) begin
    if (gtf_cm_reset) begin
      lock_s1_q <= '0;
      lock_s2_q <= '0;
      rcl_s1_q  <= '0;
      rcl_s2_q  <= '0;
    end else begin
      lock_s1_q <= qpll_lock;
      lock_s2_q <= lock_s1_q;
      rcl_s1_q  <= qpll_refclklost;
      rcl_s2_q  <= rcl_s1_q;
    end
  end

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_pll
    st_e           state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [FW-1:0] flt_q, flt_d;
    logic [RW-1:0] rty_q, rty_d;
    logic [7:0]    llc_q, llc_d;
    logic          pd_q, rs_q, le_q, rd_q, fl_q;
    logic          pd_d, rs_d, le_d, rd_d, fl_d;
    logic          en, lk, rc;

    assign en = pll_enable[g];
    assign lk = lock_s2_q[g];
    assign rc = rcl_s2_q[g];

    // Next-state, timer, lock filter, retry and lock-loss bookkeeping
    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      flt_d   = flt_q;
      rty_d   = rty_q;
      llc_d   = llc_q;
      if (!en) begin
        state_d = ST_OFF;
        tmr_d   = '0;
        flt_d   = '0;
        rty_d   = '0;
      end else begin
        unique case (state_q)
          ST_OFF: begin
            state_d = ST_PDREL;
            tmr_d   = '0;
            flt_d   = '0;
          end
          ST_PDREL: begin
            if (rc) begin
              state_d = ST_HOLD;
              tmr_d   = '0;
              flt_d   = '0;
            end else if (tmr_q == TW'(RST_CYCLES - 1)) begin
              state_d = ST_LWAIT;
              tmr_d   = '0;
              flt_d   = '0;
            end else begin
              tmr_d = tmr_q + 1'b1;
            end
          end
          ST_LWAIT: begin
            if (rc) begin
              state_d = ST_HOLD;
              tmr_d   = '0;
              flt_d   = '0;
            end else begin
              if (!lk)
                flt_d = '0;
              else if (flt_q != FW'(LOCK_FILTER))
                flt_d = flt_q + 1'b1;
              if (tmr_q != TW'(LOCK_TIMEOUT))
                tmr_d = tmr_q + 1'b1;
              // filter completion beats a coincident timeout
              if (lk && flt_q == FW'(LOCK_FILTER - 1)) begin
                state_d = ST_READY;
                rty_d   = '0;
                tmr_d   = '0;
                flt_d   = '0;
              end else if (tmr_q == TW'(LOCK_TIMEOUT - 1)) begin
                tmr_d = '0;
                flt_d = '0;
                if (rty_q < RW'(MAX_RETRY)) begin
                  rty_d   = rty_q + 1'b1;
                  state_d = ST_PDREL;
                end else begin
                  state_d = ST_FAIL;
                end
              end
            end
          end
          ST_READY: begin
            if (rc) begin
              state_d = ST_HOLD;
            end else if (!lk) begin
              state_d = ST_PDREL;
              tmr_d   = '0;
              if (llc_q != 8'hFF)
                llc_d = llc_q + 1'b1;
            end
          end
          ST_HOLD: begin
            if (!rc) begin
              state_d = ST_PDREL;
              tmr_d   = '0;
            end
          end
          ST_FAIL: begin
            state_d = ST_FAIL;
          end
          default: begin
            state_d = ST_OFF;
          end
        endcase
      end
    end

    // Decode PLL control pins from the upcoming state
    always_comb begin
      pd_d = 1'b1;
      rs_d = 1'b1;
      le_d = 1'b0;
      rd_d = 1'b0;
      fl_d = 1'b0;
      unique case (state_d)
        ST_PDREL: pd_d = 1'b0;
        ST_LWAIT: begin
          pd_d = 1'b0;
          rs_d = 1'b0;
          le_d = 1'b1;
        end
        ST_READY: begin
          pd_d = 1'b0;
          rs_d = 1'b0;
          le_d = 1'b1;
          rd_d = 1'b1;
        end
        ST_HOLD: pd_d = 1'b0;
        ST_FAIL: fl_d = 1'b1;
        default: ;
      endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge gtf_cm_drpclk) begin
      if (gtf_cm_reset) begin
        state_q <= ST_OFF;
        tmr_q   <= '0;
        flt_q   <= '0;
        rty_q   <= '0;
        llc_q   <= '0;
        pd_q    <= 1'b1;
        rs_q    <= 1'b1;
        le_q    <= 1'b0;
        rd_q    <= 1'b0;
        fl_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
        flt_q   <= flt_d;
        rty_q   <= rty_d;
        llc_q   <= llc_d;
        pd_q    <= pd_d;
        rs_q    <= rs_d;
        le_q    <= le_d;
        rd_q    <= rd_d;
        fl_q    <= fl_d;
      end
    end

    assign qpll_pd[g]              = pd_q;
    assign qpll_reset[g]           = rs_q;
    assign qpll_locken[g]          = le_q;
    assign pll_ready[g]            = rd_q;
    assign pll_fail[g]             = fl_q;
    assign pll_state[3*g +: 3]     = state_q;
    assign lock_loss_cnt[8*g +: 8] = llc_q;
  end

endmodule

// File: tb/tb_gtf_qpll_supervisor.sv
// tb_gtf_qpll_supervisor: directed plus randomized bench with a
// cycle-level behavioural model of the supervisor.
module tb_gtf_qpll_supervisor;

  localparam int NP  = 2;
  localparam int RC  = 8;
  localparam int TO  = 64;
  localparam int LF  = 4;
  localparam int MR  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] en, lock, rcl;
  logic [NP-1:0] pd, prst, len, rdy, fail;
  logic [3*NP-1:0] st;
  logic [8*NP-1:0] llc;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: 0 OFF 1 PD_REL 2 LOCK_WAIT 3 READY 4 HOLD 5 FAIL
  int m_st[NP], m_age[NP], m_run[NP], m_rty[NP], m_llc[NP];
  bit m_s1l[NP], m_s2l[NP], m_s1r[NP], m_s2r[NP];

  always #5 clk = ~clk;

  gtf_qpll_supervisor #(
    .NUM_PLL(NP), .RST_CYCLES(RC), .LOCK_TIMEOUT(TO),
    .LOCK_FILTER(LF), .MAX_RETRY(MR)
  ) dut (
    .gtf_cm_drpclk(clk),
    .gtf_cm_reset(rst),
    .pll_enable(en),
    .qpll_lock(lock),
    .qpll_refclklost(rcl),
    .qpll_pd(pd),
    .qpll_reset(prst),
    .qpll_locken(len),
    .pll_ready(rdy),
    .pll_fail(fail),
    .pll_state(st),
    .lock_loss_cnt(llc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {pd, reset, locken, ready, fail} demanded by each state
  function automatic logic [4:0] exp_io(input int s);
    case (s)
      0: return 5'b11000;
      1: return 5'b01000;
      2: return 5'b00100;
      3: return 5'b00110;
      4: return 5'b01000;
      5: return 5'b11001;
      default: return 5'bxxxxx;
    endcase
  endfunction

  task automatic model_step();
    for (int p = 0; p < NP; p++) begin
      bit lk, rc;
      lk = m_s2l[p];
      rc = m_s2r[p];
      if (rst) begin
        m_st[p] = 0; m_age[p] = 0; m_run[p] = 0;
        m_rty[p] = 0; m_llc[p] = 0;
        m_s1l[p] = 0; m_s2l[p] = 0; m_s1r[p] = 0; m_s2r[p] = 0;
        continue;
      end
      m_s2l[p] = m_s1l[p]; m_s1l[p] = lock[p];
      m_s2r[p] = m_s1r[p]; m_s1r[p] = rcl[p];
      if (!en[p]) begin
        m_st[p] = 0; m_age[p] = 0; m_run[p] = 0; m_rty[p] = 0;
        continue;
      end
      case (m_st[p])
        0: begin m_st[p] = 1; m_age[p] = 0; end
        1: begin
          if (rc) m_st[p] = 4;
          else begin
            m_age[p]++;
            if (m_age[p] == RC) begin
              m_st[p] = 2; m_age[p] = 0; m_run[p] = 0;
            end
          end
        end
        2: begin
          if (rc) m_st[p] = 4;
          else begin
            m_age[p]++;
            m_run[p] = lk ? m_run[p] + 1 : 0;
            if (m_run[p] >= LF) begin
              m_st[p] = 3; m_rty[p] = 0;
            end else if (m_age[p] >= TO) begin
              if (m_rty[p] < MR) begin
                m_rty[p]++; m_st[p] = 1; m_age[p] = 0;
              end else m_st[p] = 5;
            end
          end
        end
        3: begin
          if (rc) m_st[p] = 4;
          else if (!lk) begin
            m_st[p] = 1; m_age[p] = 0;
            if (m_llc[p] < 255) m_llc[p]++;
          end
        end
        4: if (!rc) begin m_st[p] = 1; m_age[p] = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("state%0d", p), st[3*p +: 3], m_st[p]);
      chk($sformatf("pins%0d", p),
          {pd[p], prst[p], len[p], rdy[p], fail[p]}, exp_io(m_st[p]));
      chk($sformatf("llc%0d", p), llc[8*p +: 8], m_llc[p]);
    end
  endtask

  // one clock: model the edge, let the DUT take it, compare after it
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    bit saw_rdy, was_lw;
    int seg[NP], mode[NP], rseg;
    rst = 1'b1; en = '0; lock = '0; rcl = '0;
    for (int p = 0; p < NP; p++) begin
      m_st[p] = 0; m_age[p] = 0; m_run[p] = 0; m_rty[p] = 0; m_llc[p] = 0;
      m_s1l[p] = 0; m_s2l[p] = 0; m_s1r[p] = 0; m_s2r[p] = 0;
    end
    repeat (3) cyc();
    chk("rst_pd", pd, 2'b11);
    chk("rst_reset", prst, 2'b11);
    chk("rst_state", st, 6'd0);
    rst = 1'b0;

    // power-up
    en = 2'b11;
    cyc();
    chk("pu_pd_fall", pd, 2'b00);
    repeat (19) cyc();
    lock = 2'b11;
    repeat (20) cyc();
    chk("pu_ready", rdy, 2'b11);

    // timeout and fail on PLL0
    en = 2'b00; lock = 2'b00;
    cyc();
    en = 2'b01;
    repeat (240) cyc();
    chk("to_fail", fail[0], 1'b1);
    chk("to_fail_pd", pd[0], 1'b1);
    en = 2'b00; cyc();
    en = 2'b01; cyc();
    chk("to_restart", st[2:0], 3'd1);

    // lock glitch in READY
    en = 2'b11; lock = 2'b11;
    repeat (30) cyc();
    lock[0] = 1'b0; cyc();
    lock[0] = 1'b1;
    repeat (2) cyc();
    chk("gl_pdrel", st[2:0], 3'd1);
    chk("gl_llc", llc[7:0], 8'd1);
    repeat (20) cyc();
    chk("gl_relock", rdy[0], 1'b1);

    // short lock pulses never pass the filter
    lock[0] = 1'b0;
    repeat (12) cyc();
    saw_rdy = 0;
    for (int k = 0; k < 40; k++) begin
      lock[0] = (k % 5) < 3;
      cyc();
      if (rdy[0]) saw_rdy = 1;
    end
    chk("pulse_no_ready", saw_rdy, 1'b0);

    // refclk loss in READY
    en = 2'b00; cyc();
    lock = 2'b11; en = 2'b11;
    repeat (30) cyc();
    rcl[0] = 1'b1;
    repeat (30) cyc();
    chk("rc_hold", st[2:0], 3'd4);
    chk("rc_hold_pins", {pd[0], prst[0]}, 2'b01);
    rcl[0] = 1'b0;
    repeat (3) cyc();
    chk("rc_pdrel", st[2:0], 3'd1);
    repeat (7) cyc();
    chk("rc_pdrel_end", st[2:0], 3'd1);
    cyc();
    chk("rc_lwait", st[2:0], 3'd2);

    // independence and mid-run reset
    lock = 2'b01;
    repeat (30) cyc();
    chk("ind_st0", st[2:0], 3'd3);
    chk("ind_st1", st[5:3], 3'd2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mr_pd", pd, 2'b11);
    chk("mr_reset", prst, 2'b11);
    chk("mr_outs", {len, rdy, fail}, 6'd0);
    chk("mr_state", st, 6'd0);
    chk("mr_llc", llc, 16'd0);

    // filter completes on the last LOCK_WAIT cycle
    en = 2'b00; lock = 2'b00; cyc();
    en = 2'b01;
    was_lw = 0;
    for (int k = 0; k < 200; k++) begin
      lock[0] = (m_st[0] == 2 && m_age[0] >= TO - LF - 2);
      cyc();
      if (m_st[0] == 2) was_lw = 1;
      else if (was_lw) break;
    end
    chk("bnd_ready", st[2:0], 3'd3);

    // randomized traffic
    for (int p = 0; p < NP; p++) begin seg[p] = 0; mode[p] = 0; end
    rseg = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int p = 0; p < NP; p++) begin
        if (seg[p] == 0) begin
          seg[p] = $urandom_range(60, 1);
          mode[p] = $urandom_range(3, 0);
        end
        seg[p]--;
        case (mode[p])
          0: lock[p] = 1'b0;
          1: lock[p] = 1'b1;
          2: lock[p] = ($urandom_range(7, 0) != 0);
          default: lock[p] = $urandom_range(1, 0);
        endcase
        if ($urandom_range(199, 0) == 0) en[p] = ~en[p];
        if (!en[p] && $urandom_range(9, 0) == 0) en[p] = 1'b1;
        if (rcl[p]) rcl[p] = ($urandom_range(19, 0) != 0);
        else rcl[p] = ($urandom_range(149, 0) == 0);
      end
      rst = ($urandom_range(999, 0) == 0);
      cyc();
    end
    rst = 1'b0; rcl = '0;

    // lock-loss counter saturation
    rst = 1'b1; cyc(); rst = 1'b0;
    en = 2'b01;
    for (int k = 0; k < 300; k++) begin
      lock[0] = 1'b1;
      repeat (18) cyc();
      lock[0] = 1'b0;
      cyc();
    end
    lock[0] = 1'b1;
    repeat (4) cyc();
    chk("sat_llc", llc[7:0], 8'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
